// File: rtl/rv_lsu_pkg.sv
// Shared types and helpers for the rv_lsu load/store unit.
package rv_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned STRB_W      = 16;

    // Byte-enable mask across two beats: len = 1 << size lanes starting at ofs.
    function automatic logic [STRB_W-1:0] strb_full(input logic [1:0] size, input logic [2:0] ofs);
        logic [3:0] len;
        len = 4'(1) << size;
        return STRB_W'((STRB_W'(1) << len) - STRB_W'(1)) << ofs;
    endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Combinational lane steering for rv_lsu: store shift/strobes and load assemble/extend.
module rv_lsu_align
    import rv_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    localparam int unsigned NB = XLEN / 8,
    localparam int unsigned OFS_W = $clog2(NB)
) (
    input  logic [1:0]       size,
    input  logic [OFS_W-1:0] ofs,
    input  logic             sign_ext,
    input  logic [XLEN-1:0]  wdata,
    input  logic [XLEN-1:0]  rdata_lo,
    input  logic [XLEN-1:0]  rdata_hi,
    output logic [XLEN-1:0]  wdata_lo_c,
    output logic [XLEN-1:0]  wdata_hi_c,
    output logic [NB-1:0]    strb_lo_c,
    output logic [NB-1:0]    strb_hi_c,
    output logic [XLEN-1:0]  rdata_c,
    output logic             illegal_c,
    output logic             misaligned_c,
    output logic             split_c
);

    localparam int unsigned DW = 2 * XLEN;
    localparam int unsigned SW = 2 * NB;

    logic [3:0]      len;
    logic [SW-1:0]   strb_w;
    logic [DW-1:0]   wdata_w;
    logic [XLEN-1:0] raw;

    assign len          = 4'(1) << size;
    assign illegal_c    = (XLEN == 32) && (size == SZ_D);
    assign misaligned_c = (4'(ofs) & (len - 4'd1)) != 4'd0;
    assign split_c      = (5'(ofs) + 5'(len)) > 5'(NB);

    assign strb_w                   = SW'(strb_full(size, 3'(ofs)));
    assign {strb_hi_c, strb_lo_c}   = strb_w;
    assign wdata_w                  = DW'(wdata) << {ofs, 3'b000};
    assign {wdata_hi_c, wdata_lo_c} = wdata_w;

    // Bytes of a word-crossing read come from both beats; the high beat sits above.
    assign raw = XLEN'({rdata_hi, rdata_lo} >> {ofs, 3'b000});

    always_comb begin
        rdata_c = raw;
        case (size)
            SZ_B:    rdata_c = sign_ext ? XLEN'($signed(raw[7:0]))  : XLEN'(raw[7:0]);
            SZ_H:    rdata_c = sign_ext ? XLEN'($signed(raw[15:0])) : XLEN'(raw[15:0]);
            SZ_W:    rdata_c = sign_ext ? XLEN'($signed(raw[31:0])) : XLEN'(raw[31:0]);
            default: rdata_c = raw;
        endcase
    end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit: core request/response to a beat-based memory bus with timeout.
// Define RV_LSU_MISALIGN_SPLIT_EN to run word-crossing accesses as two beats.
module rv_lsu
    import rv_lsu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic              mem_addr_ready,
    input  logic              mem_data_ready,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFS_W = $clog2(NB);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

`ifdef RV_LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic              write_q, signed_q, split_q, err_q, err_d;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q, rdata0_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              idle, accept_bad, tmo_hit, beat_d, hi_d, rsp_d;
    logic              cur_write, cur_signed;
    logic [1:0]        cur_size;
    logic [ADDR_W-1:0] cur_addr;
    logic [XLEN-1:0]   cur_wdata;
    logic [XLEN-1:0]   wdata_lo, wdata_hi, rdata_ext;
    logic [NB-1:0]     strb_lo, strb_hi;
    logic              illegal, misaligned, split;

    // In IDLE the incoming request drives the lane logic so the first beat registers directly.
    assign idle       = (state_q == ST_IDLE);
    assign cur_write  = idle ? req_write  : write_q;
    assign cur_signed = idle ? req_signed : signed_q;
    assign cur_size   = idle ? req_size   : size_q;
    assign cur_addr   = idle ? req_addr   : addr_q;
    assign cur_wdata  = idle ? req_wdata  : wdata_q;

    rv_lsu_align #(.XLEN(XLEN)) u_align (
        .size         (cur_size),
        .ofs          (cur_addr[OFS_W-1:0]),
        .sign_ext     (cur_signed),
        .wdata        (cur_wdata),
        .rdata_lo     ((state_q == ST_BEAT1) ? rdata0_q : mem_rdata),
        .rdata_hi     (mem_rdata),
        .wdata_lo_c   (wdata_lo),
        .wdata_hi_c   (wdata_hi),
        .strb_lo_c    (strb_lo),
        .strb_hi_c    (strb_hi),
        .rdata_c      (rdata_ext),
        .illegal_c    (illegal),
        .misaligned_c (misaligned),
        .split_c      (split)
    );

    assign accept_bad = illegal || (misaligned && !SPLIT_EN);
    assign tmo_hit    = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = accept_bad ? ST_RESP : ST_BEAT0;
                    err_d   = accept_bad;
                end
            end
            ST_BEAT0: begin
                if (mem_data_ready) begin
                    state_d = split_q ? ST_BEAT1 : ST_RESP;
                end else if (tmo_hit) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end
            end
            ST_BEAT1: begin
                if (mem_data_ready) begin
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign beat_d = (state_d == ST_BEAT0) || (state_d == ST_BEAT1);
    assign hi_d   = (state_d == ST_BEAT1);
    assign rsp_d  = (state_d == ST_RESP);

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            write_q        <= 1'b0;
            signed_q       <= 1'b0;
            split_q        <= 1'b0;
            err_q          <= 1'b0;
            size_q         <= 2'd0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata0_q       <= '0;
            cnt_q          <= '0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_addr_ready <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wstrb      <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (idle && req_valid) begin
                write_q  <= req_write;
                signed_q <= req_signed;
                size_q   <= req_size;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                split_q  <= SPLIT_EN && split;
            end
            if ((state_q == ST_BEAT0) && mem_data_ready) begin
                rdata0_q <= mem_rdata;
            end
            cnt_q <= (beat_d && (state_d == state_q)) ? cnt_q + CNT_W'(1) : CNT_W'(0);

            req_ready      <= (state_d == ST_IDLE);
            mem_addr_ready <= beat_d;
            mem_read       <= beat_d && !cur_write;
            mem_write      <= beat_d && cur_write;
            mem_addr       <= beat_d ? ({cur_addr[ADDR_W-1:OFS_W], OFS_W'(0)}
                                        + (hi_d ? ADDR_W'(NB) : ADDR_W'(0))) : ADDR_W'(0);
            mem_wstrb      <= (beat_d && cur_write) ? (hi_d ? strb_hi : strb_lo) : NB'(0);
            mem_wdata      <= (beat_d && cur_write) ? (hi_d ? wdata_hi : wdata_lo) : XLEN'(0);
            resp_valid     <= rsp_d;
            resp_err       <= rsp_d && err_d;
            resp_rdata     <= (rsp_d && !err_d && !write_q) ? rdata_ext : XLEN'(0);
        end
    end

endmodule

// File: tb/tb_rv_lsu.sv
// Self-checking bench for rv_lsu: XLEN=32 and XLEN=64 instances against a byte-level model.
module tb_rv_lsu;

    localparam int unsigned TMO = 4;
`ifdef RV_LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel64 = 1'b0;
    logic        rv32 = 1'b0, rv64 = 1'b0;
    logic        req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        dr = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        dr32, dr64;

    logic        rr32, vv32, re32, mr32, mw32, mar32;
    logic [31:0] rd32, ma32, mwd32;
    logic [3:0]  ms32;
    logic        rr64, vv64, re64, mr64, mw64, mar64;
    logic [63:0] rd64, mwd64;
    logic [31:0] ma64;
    logic [7:0]  ms64;

    logic        v_rr, v_rv, v_re, v_mr, v_mw, v_mar;
    logic [63:0] v_rd, v_mwd;
    logic [31:0] v_ma;
    logic [7:0]  v_ms;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign dr32 = dr & ~sel64;
    assign dr64 = dr & sel64;

    rv_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TMO)) dut32 (
        .clk(clk), .rst(rst), .req_valid(rv32), .req_ready(rr32), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .resp_valid(vv32), .resp_rdata(rd32), .resp_err(re32),
        .mem_read(mr32), .mem_write(mw32), .mem_addr(ma32), .mem_wdata(mwd32),
        .mem_wstrb(ms32), .mem_addr_ready(mar32), .mem_data_ready(dr32),
        .mem_rdata(mem_rdata[31:0])
    );

    rv_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TMO)) dut64 (
        .clk(clk), .rst(rst), .req_valid(rv64), .req_ready(rr64), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(vv64), .resp_rdata(rd64), .resp_err(re64),
        .mem_read(mr64), .mem_write(mw64), .mem_addr(ma64), .mem_wdata(mwd64),
        .mem_wstrb(ms64), .mem_addr_ready(mar64), .mem_data_ready(dr64),
        .mem_rdata(mem_rdata)
    );

    always_comb begin
        v_rr  = sel64 ? rr64  : rr32;
        v_rv  = sel64 ? vv64  : vv32;
        v_re  = sel64 ? re64  : re32;
        v_mr  = sel64 ? mr64  : mr32;
        v_mw  = sel64 ? mw64  : mw32;
        v_mar = sel64 ? mar64 : mar32;
        v_rd  = sel64 ? rd64  : {32'd0, rd32};
        v_mwd = sel64 ? mwd64 : {32'd0, mwd32};
        v_ma  = sel64 ? ma64  : ma32;
        v_ms  = sel64 ? ms64  : {4'd0, ms32};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        rv32 = v & ~sel64;
        rv64 = v & sel64;
    endtask

    // One transaction: model computes beats, strobes, data, latency and response from byte rules.
    task automatic xact(input bit s64, input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] addr, input logic [63:0] wd,
                        input logic [63:0] d0, input logic [63:0] d1, input int st0, input int st1);
        int nbm, len, ofs, nexp, exp_beats, exp_cyc, cyc, beats, wait_n, b, k, src;
        bit bad, timed, done;
        logic [31:0] base;
        logic [63:0] xmask, exp_rd, e_wd;
        logic [7:0]  e_strb;
        logic [63:0] bd [2];
        int st [2];

        nbm   = s64 ? 8 : 4;
        len   = 1 << sz;
        ofs   = int'(addr[2:0]) % nbm;
        bd[0] = d0;  bd[1] = d1;
        st[0] = st0; st[1] = st1;
        xmask = s64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        base  = addr & ~32'(nbm - 1);
        bad   = (sz == 2'd3 && !s64) || (((ofs % len) != 0) && !SPLIT);
        nexp  = bad ? 0 : ((ofs + len > nbm) ? 2 : 1);

        exp_beats = 0; timed = 1'b0; exp_cyc = 1;
        for (int i = 0; i < nexp; i++) begin
            exp_beats++;
            if (st[i] >= int'(TMO)) begin
                timed = 1'b1;
                exp_cyc += int'(TMO);
                break;
            end
            exp_cyc += st[i] + 1;
        end

        exp_rd = '0;
        if (!bad && !timed && !wr) begin
            for (int i = 0; i < len; i++) begin
                k = ofs + i;
                exp_rd[8*i +: 8] = bd[k / nbm][8*(k % nbm) +: 8];
            end
            if (sg && len < nbm && exp_rd[8*len-1])
                for (int i = 8 * len; i < 64; i++) exp_rd[i] = 1'b1;
            exp_rd &= xmask;
        end

        @(negedge clk);
        sel64 = s64;
        dr = 1'b0;
        chk("idle_req_ready", 64'(v_rr), 64'd1);
        req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
        set_valid(1'b1);
        @(posedge clk);

        cyc = 0; beats = 0; wait_n = 0; done = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            set_valid(1'($urandom));
            req_addr = $urandom; req_size = 2'($urandom); req_write = 1'($urandom);
            req_signed = 1'($urandom); req_wdata = {$urandom, $urandom};
            if (v_rv) begin
                done = 1'b1;
                set_valid(1'b0);
                dr = 1'b0;
                chk("resp_cycle", 64'(cyc), 64'(exp_cyc));
                chk("resp_beats", 64'(beats), 64'(exp_beats));
                chk("resp_err", 64'(v_re), 64'(bad || timed));
                chk("resp_rdata", v_rd, exp_rd);
            end else if (v_mar) begin
                if (wait_n == 0) beats++;
                b = (beats > 2) ? 1 : beats - 1;
                e_strb = '0; e_wd = '0;
                for (int j = 0; j < nbm; j++) begin
                    k = b * nbm + j;
                    if (k >= ofs && k < ofs + len) e_strb[j] = 1'b1;
                    src = k - ofs;
                    if (src >= 0 && src < nbm) e_wd[8*j +: 8] = wd[8*src +: 8];
                end
                if (!wr) e_strb = '0;
                chk("beat_rw", 64'({v_mr, v_mw}), 64'({!wr, wr}));
                chk("beat_addr", 64'(v_ma), 64'(base + 32'(b * nbm)));
                chk("beat_strb", 64'(v_ms), 64'(e_strb));
                if (wr) chk("beat_wdata", v_mwd & xmask, e_wd);
                chk("busy_req_ready", 64'(v_rr), 64'd0);
                if (wait_n == st[b]) begin
                    dr = 1'b1; mem_rdata = bd[b]; wait_n = 0;
                end else begin
                    dr = 1'b0; mem_rdata = {$urandom, $urandom}; wait_n++;
                end
            end else begin
                dr = 1'($urandom);
                mem_rdata = {$urandom, $urandom};
            end
        end
        chk("resp_seen", 64'(done), 64'd1);
        set_valid(1'b0);
        dr = 1'b0;
        @(negedge clk);
        chk("post_resp_valid", 64'(v_rv), 64'd0);
        chk("post_req_ready", 64'(v_rr), 64'd1);
    endtask

    task automatic reset_mid_beat();
        @(negedge clk);
        sel64 = 1'b0; dr = 1'b0;
        req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h300;
        set_valid(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_valid(1'b0);
        chk("rst_pre_beat", 64'(v_mar), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mar", 64'(v_mar), 64'd0);
        chk("rst_req_ready", 64'(v_rr), 64'd1);
        chk("rst_resp_valid", 64'(v_rv), 64'd0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_resp", 64'({v_rv, v_mar}), 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          s, w, g;
        logic [1:0]  sz;
        logic [31:0] a;
        int          s0, s1;

        repeat (3) @(negedge clk);
        chk("reset_req_ready", 64'({rr32, rr64}), 64'b11);
        chk("reset_ctl32", 64'({vv32, re32, mr32, mw32, mar32, ms32}), 64'd0);
        chk("reset_ctl64", 64'({vv64, re64, mr64, mw64, mar64, ms64}), 64'd0);
        chk("reset_data32", 64'(rd32 | ma32 | mwd32), 64'd0);
        chk("reset_data64", rd64 | mwd64 | 64'(ma64), 64'd0);
        rst = 1'b0;

        xact(0, 0, 2'd2, 0, 32'h100, 64'h0, 64'h8000_00FF, 64'h0, 0, 0);
        xact(0, 1, 2'd0, 0, 32'h103, 64'hAB, 64'h0, 64'h0, 0, 0);
        xact(0, 0, 2'd0, 1, 32'h103, 64'h0, 64'h8000_0000, 64'h0, 0, 0);
        xact(0, 0, 2'd1, 0, 32'h203, 64'h0, 64'h34AB_CDEF, 64'h5566_7712, 0, 0);
        xact(0, 1, 2'd1, 0, 32'h207, 64'hBEEF, 64'h0, 64'h0, 1, 2);
        xact(0, 0, 2'd3, 0, 32'h100, 64'h0, 64'h0, 64'h0, 0, 0);
        xact(0, 0, 2'd2, 0, 32'h400, 64'h0, 64'h1234, 64'h0, 9, 0);
        xact(0, 0, 2'd2, 1, 32'h404, 64'h0, 64'hCAFE_F00D, 64'h0, 3, 0);
        xact(1, 1, 2'd3, 0, 32'h10C, 64'h1122_3344_5566_7788, 64'h0, 64'h0, 0, 1);
        xact(1, 0, 2'd2, 1, 32'h10A, 64'h0, 64'h0000_F00D_BEEF_0000, 64'h0, 0, 0);
        xact(1, 0, 2'd3, 0, 32'h208, 64'h0, 64'h8765_4321_0FED_CBA9, 64'h0, 2, 0);
        reset_mid_beat();
        xact(0, 0, 2'd2, 0, 32'h500, 64'h0, 64'h0BAD_CAFE, 64'h0, 0, 0);

        for (int n = 0; n < 80; n++) begin
            s  = 1'($urandom);
            w  = 1'($urandom);
            g  = 1'($urandom);
            sz = 2'($urandom);
            a  = $urandom_range(0, 4095);
            s0 = ($urandom_range(0, 5) == 0) ? int'($urandom_range(3, 6)) : int'($urandom_range(0, 1));
            s1 = ($urandom_range(0, 5) == 0) ? int'($urandom_range(3, 6)) : int'($urandom_range(0, 1));
            xact(s, w, sz, g, a, {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, s0, s1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rv_lsu.md
Name: rv_lsu

Overview:
- Parametrised load/store unit between the control FSM and the external memory bus.
- Replaces the fixed 32-bit lane shift/extend logic with a sequenced unit for XLEN 32 or 64.
- Runs a registered request/response handshake toward the core and an addr-ready/data-ready handshake toward memory.
- Adds bus timeout detection and, optionally, splitting of misaligned accesses into two beats.

Parameters:
- XLEN, 32, data/bus width; legal values 32 or 64. NB = XLEN/8 byte lanes, OFS_W = log2(NB).
- ADDR_W, 32, address width.
- TIMEOUT, 255, maximum cycles a beat waits for mem_data_ready; 0 disables the timeout.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request (IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (legal only when XLEN=64).
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores.
- resp_err  out  1  qualifies resp_valid: misaligned, illegal size, or timeout.
- mem_read  out  1  read beat active.
- mem_write  out  1  write beat active.
- mem_addr  out  ADDR_W  beat address, always NB-aligned.
- mem_wdata  out  XLEN  lane-positioned store data.
- mem_wstrb  out  NB  byte enables; all zero on reads.
- mem_addr_ready  out  1  address/control valid this cycle.
- mem_data_ready  in  1  memory completes the current beat.
- mem_rdata  in  XLEN  read data, valid with mem_data_ready.

Behaviour:
- Reset: state IDLE; req_ready=1; all other outputs 0; internal registers and timeout counter cleared.
- Reset mid-beat abandons the transaction immediately: no resp_valid, and mem_addr_ready drops the next cycle.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready=1. On req_valid, latch the request.
  - Illegal size, or misaligned with the split feature off: go to RESP with err=1 and drive no bus beat.
  - Otherwise go to BEAT0.
- BEAT0: mem_addr_ready=1; mem_read/mem_write per the request; mem_addr = addr with low OFS_W bits cleared. Outputs are held stable until mem_data_ready.
  - On mem_data_ready, capture mem_rdata. If split, go to BEAT1; else go to RESP.
- BEAT1: as BEAT0 at mem_addr + NB. On mem_data_ready go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Minimum latency: accept at cycle 0, beat at cycle 1 (with mem_data_ready high), resp_valid at cycle 2. A split access adds one cycle.
- Lanes: ofs = addr[OFS_W-1:0]; len = 1<<size.
  - Full strobe = ((1<<len)-1) << ofs, 2*NB bits wide. Beat0 uses the low NB bits; beat1 the high NB bits.
  - Wdata is shifted left by ofs*8 across 2*XLEN bits and split the same way.
- Misaligned: ofs is not a multiple of len. "Split" means ofs+len > NB.
  - An access that is misaligned but stays within the word completes in one beat.
- Read assembly: {beat1_data, beat0_data} >> ofs*8, truncated to len bytes, then zero- or sign-extended per req_signed. A read beat with zero strobe is impossible by construction.
- Timeout: a counter resets on entry to each beat. When it reaches TIMEOUT without mem_data_ready:
  - go to RESP with err=1; a pending BEAT1 is not issued;
  - mem_addr_ready drops the next cycle.
- mem_data_ready outside BEAT0/BEAT1 is ignored.
- req_valid while not IDLE is ignored (req_ready=0).

Optional Feature:
- Macro: RV_LSU_MISALIGN_SPLIT_EN.
- Defined: word-crossing accesses run as two beats (BEAT0 then BEAT1) and complete with err=0.
- Undefined: any misaligned access (ofs not a multiple of len) responds err=1 with zero bus beats. BEAT1 is unreachable and may be optimised away.

Decomposition:
- Package rv_lsu_pkg holds:
  - size enum (SZ_B, SZ_H, SZ_W, SZ_D);
  - state enum;
  - function strb_full(size, ofs);
  - constant for the default timeout.
- Sub-module rv_lsu_align: combinational wdata/strobe shifter and read assemble/extend, parametrised by XLEN. The FSM, registers, and timeout counter stay in rv_lsu.

Test Plan:
- XLEN=32, lw at 0x100, mem_rdata=0x8000_00FF, data_ready on the first beat cycle -> one beat at mem_addr 0x100, resp_rdata 0x8000_00FF, resp_valid at cycle 2, err=0.
- sb at 0x103, wdata 0xAB -> mem_addr 0x100, wstrb 4'b1000, wdata 0xAB00_0000; lb signed at 0x103 with rdata 0x8000_0000 -> 0xFFFF_FF80.
- lhu at 0x203, split on -> beats at 0x200 (rdata 0x34xx_xxxx) then 0x204 (rdata 0xxxxx_xx12) -> 0x0000_1234. Split off -> err=1, no mem_addr_ready ever asserted.
- XLEN=64, sd at 0x10C, split on -> beat0 at 0x108 wstrb 0xF0, beat1 at 0x110 wstrb 0x0F. XLEN=32, size=3 -> err=1, no beats.
- TIMEOUT=4, mem_data_ready held low -> mem_addr_ready high for 4 cycles, then resp_valid with err=1; the next request is accepted normally.
- rst asserted during BEAT0 -> no resp_valid; next cycle mem_addr_ready=0 and req_ready=1.
